cnt1_stream: RTL and testbench

Streaming population counter for bit vectors that arrive as one or more BUS_WIDTH-bit sub-vector words. Vector width is selectable at run time up to MAX_VECTOR_WIDTH, and bits beyond the configured width in the final word are masked before counting. Each word is forwarded with a fixed latency, aligned to its valid flag and a last-word flag. The per-vector count is presented with the final word, so downstream similarity stages see count and data together.

---
 rtl/cnt1_stream.sv | 240 ++++++++++++++++++++++++
 tb/tb_cnt1_stream.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnt1_stream.sv
// Streaming population counter. Vectors arrive as one or more BUS_WIDTH-bit
// words. Each word is tail-masked, forwarded with a fixed latency, and
// popcounted. The per-vector total comes out alongside the vector's last word.
module cnt1_stream #(
  parameter int unsigned BUS_WIDTH        = 512,
  parameter int unsigned MAX_VECTOR_WIDTH = 2048,
  parameter int unsigned CNT_PIPE         = 3,
  parameter int unsigned CFG_WIDTH        = $clog2(MAX_VECTOR_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] i_Vector,
  input  logic                 i_Valid,
  input  logic [CFG_WIDTH-1:0] i_CfgWidth,
  output logic [BUS_WIDTH-1:0] o_SubVector,
  output logic                 o_Valid,
  output logic                 o_Last,
  output logic [CFG_WIDTH-1:0] o_Cnt,
  output logic                 o_CntNew
);

  localparam int unsigned MaxWords  = (MAX_VECTOR_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
  localparam int unsigned WordIdxW  = (MaxWords > 1) ? $clog2(MaxWords) : 1;
  localparam int unsigned PcntW     = $clog2(BUS_WIDTH + 1);
  // The tree has one leaf level plus CNT_PIPE-1 adder levels, one register each.
  localparam int unsigned NumChunks = 1 << (CNT_PIPE - 1);
  localparam int unsigned ChunkW    = (BUS_WIDTH + NumChunks - 1) / NumChunks;
  localparam int unsigned PadW      = NumChunks * ChunkW;
  localparam int unsigned NumNodes  = 2 * NumChunks - 1;

  localparam logic [CFG_WIDTH-1:0] MaxW = CFG_WIDTH'(MAX_VECTOR_WIDTH);
  localparam logic [CFG_WIDTH-1:0] BusW = CFG_WIDTH'(BUS_WIDTH);

  typedef enum logic [0:0] {StIdle, StInVec} state_e;

  // ---------------------------------------------------------------------------
  // Word counter / vector framing
  // ---------------------------------------------------------------------------
  state_e                state_q, state_d;
  logic [WordIdxW-1:0]   idx_q, idx_d;
  logic [WordIdxW-1:0]   last_idx_q, last_idx_d;
  logic [CFG_WIDTH-1:0]  tail_q, tail_d;

  logic [CFG_WIDTH-1:0]  cfg_w;
  logic [WordIdxW-1:0]   cfg_last_idx;
  logic [CFG_WIDTH-1:0]  cfg_tail;

  logic                  in_vec;
  logic [WordIdxW-1:0]   cur_idx;
  logic [WordIdxW-1:0]   cur_last_idx;
  logic [CFG_WIDTH-1:0]  cur_tail;
  logic                  word_first;
  logic                  word_last;
  logic [BUS_WIDTH-1:0]  tail_mask;
  logic [BUS_WIDTH-1:0]  word_in;

  // Clamp the configured width and derive word count and tail length.
  always_comb begin
    cfg_w        = (i_CfgWidth == '0 || i_CfgWidth > MaxW) ? MaxW : i_CfgWidth;
    cfg_last_idx = WordIdxW'((cfg_w - 1'b1) / BusW);
    cfg_tail     = cfg_w - CFG_WIDTH'(cfg_last_idx) * BusW;
  end

  // Select live config (first word) or latched config (later words); mask the tail.
  always_comb begin
    in_vec       = (state_q == StInVec);
    cur_idx      = in_vec ? idx_q : '0;
    cur_last_idx = in_vec ? last_idx_q : cfg_last_idx;
    cur_tail     = in_vec ? tail_q : cfg_tail;
    word_first   = !in_vec;
    word_last    = (cur_idx == cur_last_idx);
    // cur_tail == BUS_WIDTH shifts every bit out, leaving an all-ones mask.
    tail_mask    = ~({BUS_WIDTH{1'b1}} << cur_tail);
    word_in      = '0;
    if (i_Valid) begin
      word_in = word_last ? (i_Vector & tail_mask) : i_Vector;
    end
  end

  // Next-state for the word counter; single-word vectors never leave StIdle.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    last_idx_d = last_idx_q;
    tail_d     = tail_q;
    if (i_Valid) begin
      unique case (state_q)
        StIdle: begin
          if (cfg_last_idx != '0) begin
            state_d    = StInVec;
            idx_d      = WordIdxW'(1);
            last_idx_d = cfg_last_idx;
            tail_d     = cfg_tail;
          end
        end
        StInVec: begin
          if (idx_q == last_idx_q) begin
            state_d = StIdle;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Word counter state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      last_idx_q <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_idx_q <= last_idx_d;
      tail_q     <= tail_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Pipelined popcount tree and matching side-band delay line
  // ---------------------------------------------------------------------------
  logic [PadW-1:0]      padded;
  logic [PcntW-1:0]     chunk_cnt [NumChunks];
  logic [PcntW-1:0]     node_q    [NumNodes];
  logic [BUS_WIDTH-1:0] data_q    [CNT_PIPE];
  logic [CNT_PIPE-1:0]  vld_q;
  logic [CNT_PIPE-1:0]  first_q;
  logic [CNT_PIPE-1:0]  last_q;

  // Leaf-level popcount of each chunk of the masked word.
  always_comb begin
    padded = PadW'(word_in);
    for (int c = 0; c < NumChunks; c++) begin
      chunk_cnt[c] = '0;
      for (int j = 0; j < ChunkW; j++) begin
        chunk_cnt[c] = chunk_cnt[c] + PcntW'(padded[c * ChunkW + j]);
      end
    end
  end

  // Heap-ordered adder tree (root at node 0) plus the data/flag delay line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NumNodes; n++) begin
        node_q[n] <= '0;
      end
      for (int k = 0; k < CNT_PIPE; k++) begin
        data_q[k] <= '0;
      end
      vld_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
    end else begin
      for (int n = 0; n < NumChunks - 1; n++) begin
        node_q[n] <= node_q[2 * n + 1] + node_q[2 * n + 2];
      end
      for (int c = 0; c < NumChunks; c++) begin
        node_q[NumChunks - 1 + c] <= chunk_cnt[c];
      end
      for (int k = CNT_PIPE - 1; k >= 1; k--) begin
        data_q[k]  <= data_q[k - 1];
        vld_q[k]   <= vld_q[k - 1];
        first_q[k] <= first_q[k - 1];
        last_q[k]  <= last_q[k - 1];
      end
      data_q[0]  <= word_in;
      vld_q[0]   <= i_Valid;
      first_q[0] <= i_Valid & word_first;
      last_q[0]  <= i_Valid & word_last;
    end
  end

  // ---------------------------------------------------------------------------
  // Accumulator and output register
  // ---------------------------------------------------------------------------
  logic                 pipe_vld;
  logic                 pipe_first;
  logic                 pipe_last;
  logic [CFG_WIDTH-1:0] word_cnt;
  logic [CFG_WIDTH-1:0] vec_sum;
  logic [CFG_WIDTH-1:0] acc_q, acc_d;
  logic [CFG_WIDTH-1:0] cnt_q, cnt_d;
  logic [BUS_WIDTH-1:0] sub_q, sub_d;
  logic                 out_vld_q, out_vld_d;
  logic                 out_last_q, out_last_d;

  // First word of a vector restarts the running sum; the last word publishes it.
  always_comb begin
    pipe_vld   = vld_q[CNT_PIPE-1];
    pipe_first = first_q[CNT_PIPE-1];
    pipe_last  = last_q[CNT_PIPE-1];
    word_cnt   = CFG_WIDTH'(node_q[0]);
    vec_sum    = (pipe_first ? '0 : acc_q) + word_cnt;

    acc_d      = acc_q;
    cnt_d      = cnt_q;
    sub_d      = pipe_vld ? data_q[CNT_PIPE-1] : '0;
    out_vld_d  = pipe_vld;
    out_last_d = pipe_vld & pipe_last;
    if (pipe_vld) begin
      acc_d = vec_sum;
    end
    if (pipe_vld && pipe_last) begin
      cnt_d = vec_sum;
    end
  end

  // Output and accumulator registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      sub_q      <= '0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      sub_q      <= sub_d;
      out_vld_q  <= out_vld_d;
      out_last_q <= out_last_d;
    end
  end

  assign o_SubVector = sub_q;
  assign o_Valid     = out_vld_q;
  assign o_Last      = out_last_q;
  // The count updates exactly on last-word cycles, so the pulse shares o_Last's flop.
  assign o_CntNew    = out_last_q;
  assign o_Cnt       = cnt_q;

endmodule

// File: tb/tb_cnt1_stream.sv
// Scoreboard bench for cnt1_stream: each driven word pushes its expected
// output (cycle, flags, count, masked data); a monitor logs every non-idle
// output cycle and each scenario task pops and compares both queues.
module tb_cnt1_stream;

  localparam int BW   = 512;
  localparam int MAXW = 2048;
  localparam int CW   = 12;
  localparam int LAT  = 4;

  typedef struct packed {
    int unsigned   cyc;
    logic          valid;
    logic          last;
    logic          cnt_new;
    logic [CW-1:0] cnt;
    logic [BW-1:0] data;
  } out_t;

  logic          clk;
  logic          rst;
  logic [BW-1:0] i_Vector;
  logic          i_Valid;
  logic [CW-1:0] i_CfgWidth;
  logic [BW-1:0] o_SubVector;
  logic          o_Valid;
  logic          o_Last;
  logic [CW-1:0] o_Cnt;
  logic          o_CntNew;

  out_t        exp_q[$];
  out_t        obs_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  // Reference model state.
  int m_pos = 0;
  int m_w = 0;
  int m_words = 0;
  int m_acc = 0;
  int m_cnt = 0;

  cnt1_stream #(
    .BUS_WIDTH       (BW),
    .MAX_VECTOR_WIDTH(MAXW),
    .CNT_PIPE        (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_Vector   (i_Vector),
    .i_Valid    (i_Valid),
    .i_CfgWidth (i_CfgWidth),
    .o_SubVector(o_SubVector),
    .o_Valid    (o_Valid),
    .o_Last     (o_Last),
    .o_Cnt      (o_Cnt),
    .o_CntNew   (o_CntNew)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log any cycle where some output is not idle.
  always @(negedge clk) begin
    if (!rst && (o_Valid || o_Last || o_CntNew || o_SubVector != '0))
      obs_q.push_back({cyc, o_Valid, o_Last, o_CntNew, o_Cnt, o_SubVector});
  end

  // Drive one valid word for one cycle and push its expected output.
  task automatic drive_word(input logic [BW-1:0] v, input logic [CW-1:0] cfg);
    out_t          e;
    logic [BW-1:0] mv;
    bit            last;
    int            tail;
    i_Vector   = v;
    i_Valid    = 1'b1;
    i_CfgWidth = cfg;
    if (m_pos == 0) begin
      m_w     = (cfg == 0 || int'(cfg) > MAXW) ? MAXW : int'(cfg);
      m_words = (m_w + BW - 1) / BW;
    end
    last = (m_pos == m_words - 1);
    mv   = v;
    if (last) begin
      tail = m_w - (m_words - 1) * BW;
      for (int b = tail; b < BW; b++) mv[b] = 1'b0;
    end
    m_acc = (m_pos == 0) ? $countones(mv) : m_acc + $countones(mv);
    if (last) begin
      m_cnt = m_acc;
      m_pos = 0;
    end else begin
      m_pos++;
    end
    e.cyc     = cyc + LAT;
    e.valid   = 1'b1;
    e.last    = last;
    e.cnt_new = last;
    e.cnt     = CW'(m_cnt);
    e.data    = mv;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    i_Valid    = 1'b0;
    i_Vector   = '1;      // junk while not valid
    i_CfgWidth = 12'd5;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++; if (o_Valid !== 1'b0) begin errors++; $display("FAIL reset o_Valid got %b want 0", o_Valid); end
    checks++; if (o_Last !== 1'b0) begin errors++; $display("FAIL reset o_Last got %b want 0", o_Last); end
    checks++; if (o_CntNew !== 1'b0) begin errors++; $display("FAIL reset o_CntNew got %b want 0", o_CntNew); end
    checks++; if (o_Cnt !== '0) begin errors++; $display("FAIL reset o_Cnt got %0d want 0", o_Cnt); end
    checks++; if (o_SubVector !== '0) begin errors++; $display("FAIL reset o_SubVector got %h want 0", o_SubVector); end
    @(negedge clk);
    #2 rst = 1'b0;
    idle(2);
  endtask

  task automatic test_two_word();
    out_t e, o;
    drive_word('1, 12'd920);
    drive_word('1, 12'd920);
    repeat (LAT + 3) @(negedge clk);
    #2;
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = '0; o = '0;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL two_word got %h want %h", o, e); end
    end
  endtask

  task automatic test_single_word();
    out_t e, o;
    drive_word({{(BW-16){1'b0}}, 16'h0F0F}, 12'd512);
    idle(1);
    drive_word('1, 12'd8);       // re-latches width: proves the counter stayed idle
    repeat (LAT + 3) @(negedge clk);
    #2;
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = '0; o = '0;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL single_word got %h want %h", o, e); end
    end
  endtask

  task automatic test_gaps();
    out_t e, o;
    drive_word(512'h1, 12'd2048);
    drive_word(512'h3, 12'd2048);
    idle(2);
    drive_word(512'h7, 12'd2048);
    drive_word(512'hF, 12'd2048);
    repeat (LAT + 3) @(negedge clk);
    #2;
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = '0; o = '0;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL gaps got %h want %h", o, e); end
    end
  endtask

  task automatic test_back_to_back();
    out_t e, o;
    drive_word('1, 12'd920);
    drive_word('1, 12'd920);
    drive_word('1, 12'd100);
    repeat (LAT + 3) @(negedge clk);
    #2;
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = '0; o = '0;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL back_to_back got %h want %h", o, e); end
    end
  endtask

  task automatic test_clamp();
    out_t          e, o;
    logic [BW-1:0] v;
    for (int r = 0; r < 2; r++) begin
      for (int w = 0; w < 4; w++) begin
        for (int k = 0; k < BW / 32; k++) v[k*32 +: 32] = $urandom();
        // Later words carry a different width that must be ignored.
        drive_word(v, (w == 0) ? ((r == 0) ? 12'd0 : 12'd3000) : 12'd37);
      end
    end
    repeat (LAT + 3) @(negedge clk);
    #2;
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = '0; o = '0;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL clamp got %h want %h", o, e); end
    end
  endtask

  task automatic test_async_reset();
    out_t e, o;
    drive_word('1, 12'd512);     // leaves o_Cnt = 512 so the reset clear is visible
    drive_word('1, 12'd2048);    // word 1 of 4
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;               // mid-cycle, away from any clock edge
    #1;
    checks++; if (o_Valid !== 1'b0) begin errors++; $display("FAIL async_rst o_Valid got %b want 0", o_Valid); end
    checks++; if (o_Cnt !== '0) begin errors++; $display("FAIL async_rst o_Cnt got %0d want 0", o_Cnt); end
    checks++; if (o_SubVector !== '0) begin errors++; $display("FAIL async_rst o_SubVector got %h want 0", o_SubVector); end
    checks++; if (o_CntNew !== 1'b0 || o_Last !== 1'b0) begin
      errors++; $display("FAIL async_rst flags got last=%b new=%b want 0 0", o_Last, o_CntNew);
    end
    m_pos = 0; m_acc = 0; m_cnt = 0;
    @(negedge clk);
    #2 rst = 1'b0;
    idle(1);
    drive_word({{(BW-7){1'b0}}, 7'h7F}, 12'd512);
    repeat (LAT + 3) @(negedge clk);
    #2;
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = '0; o = '0;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL async_reset got %h want %h", o, e); end
    end
  endtask

  initial begin
    rst        = 1'b0;
    i_Vector   = '0;
    i_Valid    = 1'b0;
    i_CfgWidth = '0;
    #3;
    test_reset();
    test_two_word();
    test_single_word();
    test_gaps();
    test_back_to_back();
    test_clamp();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
